vx_fetch_sched: RTL and testbench
=================================

Name: vx_fetch_sched

Overview:
- Fetch-side warp scheduler. Picks one eligible warp per cycle round-robin and presents its PC, thread mask, warp id and a fresh uuid to the fetch stage over a registered valid/ready channel.
- Eligibility has two conditions. A warp may have at most one outstanding icache fetch. It must also hold an instruction-buffer credit.
- Sits between warp-control state and the fetch unit. It guarantees the ibuffer can never overflow, so fetch needs no local pending-size tracking.

Parameters:
- NUM_WARPS, 4, number of warps; NW_WIDTH = max(1, clog2(NUM_WARPS)).
- NUM_THREADS, 4, threads per warp (tmask width).
- PC_BITS, 31, halfword-aligned PC width.
- UUID_WIDTH, 8, instruction uuid width.
- IBUF_SIZE, 4, ibuffer entries per warp (initial credits); CW = clog2(IBUF_SIZE+1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- warp_valid  in  NUM_WARPS  warp w active and wants to fetch.
- warp_pc  in  NUM_WARPS*PC_BITS  per-warp next PC, warp w at [w*PC_BITS +: PC_BITS].
- warp_tmask  in  NUM_WARPS*NUM_THREADS  per-warp thread mask.
- sched_valid  out  1  issue entry valid.
- sched_wid  out  NW_WIDTH  issued warp id.
- sched_pc  out  PC_BITS  issued PC.
- sched_tmask  out  NUM_THREADS  issued thread mask.
- sched_uuid  out  UUID_WIDTH  issued uuid.
- sched_ready  in  1  fetch accepts entry.
- rsp_fire  in  1  fetch response handed to decode.
- rsp_wid  in  NW_WIDTH  warp of that response.
- ibuf_pop  in  NUM_WARPS  one ibuffer entry of warp w consumed.

Behaviour:
- Reset (asynchronous, reset_n=0) sets:
  - sched_valid=0; sched_wid/pc/tmask/uuid=0.
  - pending[w]=0 and credit[w]=IBUF_SIZE for all w.
  - rr_ptr=0; uuid counter=0.
- Reset asserted mid-transfer drops the entry; nothing is retained.
- Eligible[w] = warp_valid[w] & ~pending[w] & (credit[w]!=0).
- Load condition: load = (~sched_valid | sched_ready) & |eligible.
- Arbitration on load:
  - Grant the first eligible warp at or after rr_ptr, wrapping.
  - Capture the granted warp's id, pc and tmask, plus uuid_ctr, into the output register.
  - sched_valid=1 next cycle.
  - rr_ptr = grant+1 mod NUM_WARPS.
  - uuid_ctr increments and wraps at 2^UUID_WIDTH.
- Side effects of a grant to warp w, applied in the same cycle as the load:
  - pending[w] is set.
  - credit[w] decrements.
  - These are applied at grant, not at handshake, so the warp cannot be re-granted while its entry waits.
- Handshake:
  - While sched_valid=1 and sched_ready=0, all sched_* outputs hold stable.
  - Dropping warp_valid does not retract a loaded entry.
  - If sched_ready=1 and no warp is eligible, sched_valid falls to 0 the next cycle.
- Latency and throughput:
  - warp_valid rising at cycle N (warp idle, credits present) gives sched_valid=1 at N+1.
  - Back-to-back issue, one per cycle, to distinct warps.
- Response handling: rsp_fire clears pending[rsp_wid] the next cycle.
  - The cleared warp is eligible from the following cycle.
  - No same-cycle bypass.
- Credits:
  - ibuf_pop[w] increments credit[w].
  - A grant and a pop to the same warp in the same cycle leave credit unchanged.
  - A pop when credit[w]==IBUF_SIZE is a protocol error: credit holds, and a simulation-only assertion fires.
  - rsp_fire for a warp with pending=0 is also an error: ignored, assertion fires.
- Boundary cases:
  - NUM_WARPS=1: rr_ptr is constant 0.
  - credit==0 blocks the warp even when pending=0.

Optional Feature:
- Macro: FETCH_SCHED_PERF_EN.
- When defined, adds two outputs, both 32-bit, both reset to 0, both saturating at all-ones:
  - perf_issue_cnt: counts sched_valid&sched_ready handshakes.
  - perf_stall_cnt: counts cycles where |warp_valid=1, eligible=0 and the output register is empty or being drained.
- When undefined, those ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then warp_valid=4'b1111 with all PCs distinct and sched_ready=1 held. Required: grants wid 0,1,2,3 on consecutive cycles with uuids 0,1,2,3. Then sched_valid=0, because all warps are pending.
- Warp 2 issued, rsp_fire with rsp_wid=2 at cycle T. Required: warp 2 not granted at T+1; granted at T+2 with uuid incremented.
- Warp 0 only, IBUF_SIZE=4, rsp_fire returned after every issue, no ibuf_pop. Required: exactly 4 issues, then stall. One ibuf_pop[0] gives exactly one further issue.
- sched_ready=0 for 5 cycles after a grant to warp 1, while warp_pc for warp 1 changes. Required: sched_pc/wid/uuid stay stable; on sched_ready=1 the entry retires and the next eligible warp (2) loads.
- Same-cycle grant to warp 3 and ibuf_pop[3] with credit=2. Required: credit stays 2.
- Async reset pulsed mid-stall with sched_valid=1. Required: sched_valid=0 immediately, all credits restored to 4, uuid restarts at 0.

Source files
------------

// File: rtl/vx_fetch_sched.sv
// vx_fetch_sched: round-robin fetch warp scheduler gated by one outstanding fetch and ibuffer credits per warp.
// Define FETCH_SCHED_PERF_EN to add saturating issue/stall performance counters.
module vx_fetch_sched #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 31,
    parameter int UUID_WIDTH  = 8,
    parameter int IBUF_SIZE   = 4,
    localparam int NW_WIDTH   = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1,
    localparam int CW         = $clog2(IBUF_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_WARPS-1:0]             warp_valid_i,
    input  logic [NUM_WARPS*PC_BITS-1:0]     warp_pc_i,
    input  logic [NUM_WARPS*NUM_THREADS-1:0] warp_tmask_i,
    output logic                             sched_valid_o,
    output logic [NW_WIDTH-1:0]              sched_wid_o,
    output logic [PC_BITS-1:0]               sched_pc_o,
    output logic [NUM_THREADS-1:0]           sched_tmask_o,
    output logic [UUID_WIDTH-1:0]            sched_uuid_o,
    input  logic                             sched_ready_i,
    input  logic                             rsp_fire_i,
    input  logic [NW_WIDTH-1:0]              rsp_wid_i,
`ifdef FETCH_SCHED_PERF_EN
    output logic [31:0]                      perf_issue_cnt_o,
    output logic [31:0]                      perf_stall_cnt_o,
`endif
    input  logic [NUM_WARPS-1:0]             ibuf_pop_i
);
    logic [NUM_WARPS-1:0]   pending_q, pending_d, eligible, full;
    logic [CW-1:0]          credit_q [NUM_WARPS];
    logic [CW-1:0]          credit_d [NUM_WARPS];
    logic [NW_WIDTH-1:0]    rr_q, rr_d, grant;
    logic [UUID_WIDTH-1:0]  uuid_q;
    logic                   valid_q, found, load;
    logic [NW_WIDTH-1:0]    wid_q;
    logic [PC_BITS-1:0]     pc_q;
    logic [NUM_THREADS-1:0] tmask_q;
    logic [UUID_WIDTH-1:0]  suuid_q;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            full[w]     = credit_q[w] == CW'(IBUF_SIZE);
            eligible[w] = warp_valid_i[w] & ~pending_q[w] & (credit_q[w] != '0);
        end
    end

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!found && eligible[(int'(rr_q) + i) % NUM_WARPS]) begin
                found = 1'b1;
                grant = NW_WIDTH'((int'(rr_q) + i) % NUM_WARPS);
            end
        end
    end

    assign load = (~valid_q | sched_ready_i) & found;
    assign rr_d = NW_WIDTH'((int'(grant) + 1) % NUM_WARPS);

    // Grant-time side effects keep a waiting entry's warp from being re-granted.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_d[w] = (load && grant == NW_WIDTH'(w)) |
                           (pending_q[w] & ~(rsp_fire_i && rsp_wid_i == NW_WIDTH'(w)));
            credit_d[w]  = credit_q[w] + CW'(ibuf_pop_i[w] & ~full[w])
                           - CW'(load && grant == NW_WIDTH'(w));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            for (int w = 0; w < NUM_WARPS; w++) credit_q[w] <= CW'(IBUF_SIZE);
            rr_q    <= '0;
            uuid_q  <= '0;
            valid_q <= 1'b0;
            wid_q   <= '0;
            pc_q    <= '0;
            tmask_q <= '0;
            suuid_q <= '0;
        end else begin
            pending_q <= pending_d;
            credit_q  <= credit_d;
            if (load) begin
                rr_q    <= rr_d;
                uuid_q  <= uuid_q + UUID_WIDTH'(1);
                valid_q <= 1'b1;
                wid_q   <= grant;
                pc_q    <= warp_pc_i[int'(grant)*PC_BITS +: PC_BITS];
                tmask_q <= warp_tmask_i[int'(grant)*NUM_THREADS +: NUM_THREADS];
                suuid_q <= uuid_q;
            end else if (sched_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign sched_valid_o = valid_q;
    assign sched_wid_o   = wid_q;
    assign sched_pc_o    = pc_q;
    assign sched_tmask_o = tmask_q;
    assign sched_uuid_o  = suuid_q;

`ifdef FETCH_SCHED_PERF_EN
    logic [31:0] issue_q, stall_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            if (valid_q && sched_ready_i && !(&issue_q)) issue_q <= issue_q + 32'd1;
            if (|warp_valid_i && !(|eligible) && (!valid_q || sched_ready_i) && !(&stall_q))
                stall_q <= stall_q + 32'd1;
        end
    end
    assign perf_issue_cnt_o = issue_q;
    assign perf_stall_cnt_o = stall_q;
`endif

`ifndef SYNTHESIS
    a_rsp_pending: assert property (@(posedge clk) disable iff (!reset_n)
        rsp_fire_i |-> pending_q[rsp_wid_i]);
    a_pop_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (ibuf_pop_i & full) == '0);
`endif
endmodule

// File: tb/tb_vx_fetch_sched.sv
// tb_vx_fetch_sched: vector table, corner sequences and random traffic checked against a cycle model.
module tb_vx_fetch_sched;
    localparam int NW = 4;
    localparam int IB = 4;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [3:0] wv = '0, pop = '0;
    logic rdy = 1'b0, rsp = 1'b0;
    logic [1:0] rspw = '0;
    logic [3:0][30:0] pcs;
    logic [3:0][3:0] tm;
    logic sv;
    logic [1:0] swid;
    logic [30:0] spc;
    logic [3:0] stm;
    logic [7:0] suu;
`ifdef FETCH_SCHED_PERF_EN
    logic [31:0] p_issue, p_stall;
`endif
    int n_chk = 0, n_fail = 0;

    bit m_valid;
    int m_wid, m_uuid, m_ctr, m_rr;
    logic [30:0] m_pc;
    logic [3:0] m_tm;
    bit m_pend [NW];
    int m_cred [NW];

    typedef struct {
        logic [3:0] wv; logic rdy; logic rsp; logic [1:0] rw; logic [3:0] pop;
        logic ev; logic [1:0] ew; logic [7:0] eu;
    } vec_t;
    vec_t tbl [8];

    vx_fetch_sched dut (
        .clk(clk), .reset_n(reset_n),
        .warp_valid_i(wv), .warp_pc_i(pcs), .warp_tmask_i(tm),
        .sched_valid_o(sv), .sched_wid_o(swid), .sched_pc_o(spc),
        .sched_tmask_o(stm), .sched_uuid_o(suu), .sched_ready_i(rdy),
        .rsp_fire_i(rsp), .rsp_wid_i(rspw),
`ifdef FETCH_SCHED_PERF_EN
        .perf_issue_cnt_o(p_issue), .perf_stall_cnt_o(p_stall),
`endif
        .ibuf_pop_i(pop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_wid = 0; m_uuid = 0; m_ctr = 0; m_rr = 0; m_pc = '0; m_tm = '0;
        for (int w = 0; w < NW; w++) begin m_pend[w] = 0; m_cred[w] = IB; end
    endtask

    // One clock of the scheduler's rules applied to the inputs currently driven.
    task automatic model_eval();
        bit el [NW];
        bit any, ld;
        int g;
        any = 0; g = -1;
        for (int w = 0; w < NW; w++) begin
            el[w] = wv[w] && !m_pend[w] && m_cred[w] > 0;
            any |= el[w];
        end
        for (int k = 0; k < NW; k++) if (g < 0 && el[(m_rr + k) % NW]) g = (m_rr + k) % NW;
        ld = (!m_valid || rdy) && any;
        if (rsp) m_pend[rspw] = 0;
        for (int w = 0; w < NW; w++) if (pop[w] && m_cred[w] < IB) m_cred[w]++;
        if (ld) begin
            m_pend[g] = 1; m_cred[g]--;
            m_valid = 1; m_wid = g; m_pc = pcs[g]; m_tm = tm[g];
            m_uuid = m_ctr; m_ctr = (m_ctr + 1) % 256; m_rr = (g + 1) % NW;
        end else if (rdy) m_valid = 0;
    endtask

    task automatic step();
        model_eval();
        @(posedge clk); #1;
        chk("valid", sv, m_valid);
        if (m_valid) begin
            chk("wid", swid, m_wid);
            chk("pc", spc, m_pc);
            chk("tmask", stm, m_tm);
            chk("uuid", suu, m_uuid);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; wv = '0; rdy = 0; rsp = 0; pop = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        int issues;
        bit seen;
        logic [30:0] pc1;
        for (int w = 0; w < NW; w++) begin
            pcs[w] = 31'(32'h100 * (w + 1));
            tm[w]  = 4'(1 << w) | 4'h1;
        end
        tbl[0] = '{4'hF, 1, 0, 2'd0, 4'h0, 1, 2'd0, 8'd0};
        tbl[1] = '{4'hF, 1, 0, 2'd0, 4'h0, 1, 2'd1, 8'd1};
        tbl[2] = '{4'hF, 1, 0, 2'd0, 4'h0, 1, 2'd2, 8'd2};
        tbl[3] = '{4'hF, 1, 0, 2'd0, 4'h0, 1, 2'd3, 8'd3};
        tbl[4] = '{4'hF, 1, 0, 2'd0, 4'h0, 0, 2'd0, 8'd0};
        tbl[5] = '{4'hF, 1, 1, 2'd2, 4'h0, 0, 2'd0, 8'd0};
        tbl[6] = '{4'hF, 1, 0, 2'd0, 4'h0, 1, 2'd2, 8'd4};
        tbl[7] = '{4'hF, 1, 0, 2'd0, 4'h0, 0, 2'd0, 8'd0};

        do_reset();
        chk("rst_valid", sv, 0);
        chk("rst_wid", swid, 0);
        chk("rst_pc", spc, 0);
        chk("rst_tmask", stm, 0);
        chk("rst_uuid", suu, 0);
        for (int w = 0; w < NW; w++) chk($sformatf("rst_credit%0d", w), dut.credit_q[w], IB);

        for (int i = 0; i < 8; i++) begin
            wv = tbl[i].wv; rdy = tbl[i].rdy; rsp = tbl[i].rsp; rspw = tbl[i].rw; pop = tbl[i].pop;
            step();
            chk($sformatf("tbl%0d_valid", i), sv, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_wid", i), swid, tbl[i].ew);
                chk($sformatf("tbl%0d_uuid", i), suu, tbl[i].eu);
                chk($sformatf("tbl%0d_pc", i), spc, pcs[tbl[i].ew]);
            end
        end
        rsp = 0;

        // Credit exhaustion on warp 0, then one pop buys exactly one more issue.
        do_reset();
        wv = 4'b0001; rdy = 1; rspw = 0; issues = 0;
        for (int c = 0; c < 16; c++) begin
            rsp = m_pend[0];
            step();
            if (sv) issues++;
        end
        chk("credit_issues", issues, 4);
        chk("credit_zero", dut.credit_q[0], 0);
        rsp = 0; pop = 4'b0001;
        step();
        pop = '0;
        for (int c = 0; c < 6; c++) begin
            rsp = m_pend[0];
            step();
            if (sv) issues++;
        end
        chk("pop_reissue", issues, 5);
        rsp = 0;

        // Output held under backpressure while warp 1's PC moves.
        do_reset();
        wv = 4'b0110; rdy = 0;
        step();
        chk("hold_first_wid", swid, 1);
        pc1 = pcs[1];
        for (int c = 0; c < 5; c++) begin
            pcs[1] = 31'($urandom);
            step();
            chk("hold_valid", sv, 1);
            chk("hold_wid", swid, 1);
            chk("hold_pc", spc, pc1);
            chk("hold_uuid", suu, 0);
        end
        rdy = 1;
        step();
        chk("retire_next_wid", swid, 2);
        chk("retire_next_uuid", suu, 1);

        // Grant and pop hitting warp 3 in the same cycle with credit 2.
        do_reset();
        wv = 4'b1000; rdy = 1; rspw = 3; seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            rsp = m_pend[3];
            pop = (!m_pend[3] && m_cred[3] == 2) ? 4'b1000 : 4'b0000;
            step();
            if (pop[3]) begin
                seen = 1;
                chk("grant_pop_wid", swid, 3);
                chk("grant_pop_credit", dut.credit_q[3], 2);
            end
        end
        chk("grant_pop_seen", seen, 1);
        rsp = 0; pop = '0;

        // Asynchronous reset while an entry is stalled.
        do_reset();
        wv = 4'b0001; rdy = 0;
        step(); step();
        #2 reset_n = 0;
        #1;
        chk("async_valid", sv, 0);
        for (int w = 0; w < NW; w++) chk($sformatf("async_credit%0d", w), dut.credit_q[w], IB);
        model_reset();
        rdy = 1;
        @(negedge clk);
        reset_n = 1;
        step();
        chk("async_restart_wid", swid, 0);
        chk("async_restart_uuid", suu, 0);

        // Random traffic against the model; only protocol-legal responses and pops.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            wv = 4'($urandom);
            rdy = $urandom_range(0, 3) != 0;
            for (int w = 0; w < NW; w++) begin
                pcs[w] = 31'($urandom);
                tm[w]  = 4'($urandom);
                pop[w] = m_cred[w] < IB && $urandom_range(0, 2) == 0;
            end
            rspw = 2'($urandom);
            rsp  = m_pend[rspw] && $urandom_range(0, 1) == 1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
